pipelined_adder: RTL

- Parametrised successor to the single-bit full adder: a WIDTH-bit carry-chain adder split into STAGES pipeline stages.
- Each stage adds one WIDTH/STAGES-bit chunk and registers the carry into the next stage.
- Valid/ready handshakes on input and output; throughput of one add per cycle.
- Arithmetic datapath primitive for downstream accumulators and ALU work.

---
 rtl/adder_pkg.sv | 17 +
 rtl/adder_chunk.sv | 25 ++
 rtl/pipelined_adder.sv | 128 ++++++++++++
 3 files changed

// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined adder: default geometry, chunk-width helper
// and the registered result-flag bundle of the final stage.
package adder_pkg;

    localparam int DEFAULT_WIDTH  = 8;
    localparam int DEFAULT_STAGES = 2;

    function automatic int chunk_width(input int width, input int stages);
        return width / stages;
    endfunction

    typedef struct packed {
        logic cout;
        logic overflow;
    } result_flags_t;

endpackage

// File: rtl/adder_chunk.sv
// Combinational CW-bit add of two operand chunks plus carry; also exposes the
// carry into the chunk MSB so the last stage can derive signed overflow.
module adder_chunk #(
    parameter int CW = 4
) (
    input  logic [CW-1:0] a,
    input  logic [CW-1:0] b,
    input  logic          carry_in,
    output logic [CW-1:0] sum,
    output logic          carry_out,
    output logic          carry_msb
);

    logic [CW:0] total;

    always_comb begin
        total = {1'b0, a} + {1'b0, b} + {{CW{1'b0}}, carry_in};
    end

    assign sum       = total[CW-1:0];
    assign carry_out = total[CW];
    // Carry into the MSB is recovered from the MSB sum bit and its operands.
    assign carry_msb = a[CW-1] ^ b[CW-1] ^ total[CW-1];

endmodule

// File: rtl/pipelined_adder.sv
// WIDTH-bit adder split into STAGES carry-chained pipeline stages with valid/ready flow.
// Define PIPELINED_ADDER_SUB_EN to add a 'sub' input that turns the block into a-b.
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int STAGES = DEFAULT_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef PIPELINED_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int CW = chunk_width(WIDTH, STAGES);

    // sum_lo holds finished low chunks; a_hi/b_hi carry the operand chunks still to be added.
    typedef struct packed {
        logic [WIDTH-1:0] sum_lo;
        logic [WIDTH-1:0] a_hi;
        logic [WIDTH-1:0] b_hi;
        logic             carry;
        logic             valid;
    } stage_t;

    stage_t        stage_q [STAGES];
    stage_t        up      [STAGES];
    stage_t        nxt     [STAGES];
    logic          ready   [STAGES];
    logic [CW-1:0] chunk_sum [STAGES];
    logic          chunk_co  [STAGES];
    logic          chunk_msb [STAGES];
    result_flags_t flags_q;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;

`ifdef PIPELINED_ADDER_SUB_EN
    assign b_eff   = sub ? ~b : b;
    assign cin_eff = sub ? 1'b1 : cin;
`else
    assign b_eff   = b;
    assign cin_eff = cin;
`endif

    always_comb begin
        up[0].sum_lo = '0;
        up[0].a_hi   = a;
        up[0].b_hi   = b_eff;
        up[0].carry  = cin_eff;
        up[0].valid  = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            up[k] = stage_q[k-1];
        end
    end

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        adder_chunk #(.CW(CW)) u_chunk (
            .a         (up[g].a_hi[g*CW +: CW]),
            .b         (up[g].b_hi[g*CW +: CW]),
            .carry_in  (up[g].carry),
            .sum       (chunk_sum[g]),
            .carry_out (chunk_co[g]),
            .carry_msb (chunk_msb[g])
        );
    end

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            nxt[k]                      = up[k];
            nxt[k].sum_lo[k*CW +: CW]   = chunk_sum[k];
            nxt[k].carry                = chunk_co[k];
        end
    end

    // NOTE: the ready chain walks back through a block-local variable so the
    // array is only ever written, never read, inside this block (no comb loop).
    always_comb begin
        logic r;
        r = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            r        = !stage_q[k].valid || r;
            ready[k] = r;
        end
    end

    // NOTE: data registers are reset as well as valid flags so the outputs read
    // all-zero out of reset, not just "invalid".
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                stage_q[k] <= '0;
            end
            flags_q <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (ready[k]) begin
                    if (up[k].valid) begin
                        stage_q[k] <= nxt[k];
                    end else begin
                        stage_q[k].valid <= 1'b0;
                    end
                end
            end
            if (ready[STAGES-1] && up[STAGES-1].valid) begin
                flags_q.cout     <= chunk_co[STAGES-1];
                flags_q.overflow <= chunk_co[STAGES-1] ^ chunk_msb[STAGES-1];
            end
        end
    end

    assign in_ready  = ready[0];
    assign out_valid = stage_q[STAGES-1].valid;
    assign sum       = stage_q[STAGES-1].sum_lo;
    assign cout      = flags_q.cout;
    assign overflow  = flags_q.overflow;

endmodule
